// File: rtl/aq_axis_djpeg_vout.sv
// Buffers decoder pixels and re-emits them as a 32-bit AXI4-Stream video master (TUSER=SOF, TLAST=EOL).
// Write-to-TVALID latency is two edges; TREADY stalls are absorbed by the FIFO and IN_HOLD throttles the decoder.
module aq_axis_djpeg_vout #(
   parameter int DEPTH_LOG2   = 9,
   parameter int AFULL_MARGIN = 64
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  CLEAR,
   input  logic                  PIX_VALID,
   input  logic [15:0]           PIX_X,
   input  logic [15:0]           PIX_Y,
   input  logic [15:0]           PIX_WIDTH,
   input  logic [15:0]           PIX_HEIGHT,
   input  logic [7:0]            PIX_R,
   input  logic [7:0]            PIX_G,
   input  logic [7:0]            PIX_B,
   output logic [31:0]           M_AXIS_TDATA,
   output logic                  M_AXIS_TVALID,
   input  logic                  M_AXIS_TREADY,
   output logic                  M_AXIS_TLAST,
   output logic                  M_AXIS_TUSER,
   output logic                  IN_HOLD,
   output logic [DEPTH_LOG2:0]   LEVEL,
   output logic                  OVERFLOW,
   output logic                  FRAME_ERR,
   output logic                  FRAME_BUSY,
   output logic                  FRAME_DONE
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   LVL_FULL   = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LVL_MARGIN = (DEPTH_LOG2+1)'(AFULL_MARGIN);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

   typedef struct packed {
      logic        sof;
      logic        eol;
      logic        eof;
      logic [23:0] rgb;
   } entry_t;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   entry_t                mem [DEPTH];
   entry_t                wr_ent;
   entry_t                out_ent;
   logic                  out_vld;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   mem_cnt;
   logic [DEPTH_LOG2:0]   level;
   logic [DEPTH_LOG2:0]   level_nxt;
   logic                  wr_sof;
   logic                  wr_eol;
   logic                  wr_eof;
   logic                  pop;
   logic                  wr_acc;
   logic                  load;
   logic                  frame_done;
   logic                  in_hold;
   logic                  overflow;
   logic                  frame_err;
   logic                  frame_busy;
   state_t                state;

   // 16-bit modulo compares: WIDTH=0 makes the last column 0xFFFF.
   assign wr_sof = (PIX_X == 16'd0) && (PIX_Y == 16'd0);
   assign wr_eol = (PIX_X == (PIX_WIDTH - 16'd1));
   assign wr_eof = wr_eol && (PIX_Y == (PIX_HEIGHT - 16'd1));
   assign wr_ent = {wr_sof, wr_eol, wr_eof, PIX_R, PIX_G, PIX_B};

   assign pop    = out_vld && M_AXIS_TREADY && !CLEAR;
   assign wr_acc = PIX_VALID && !CLEAR && ((level != LVL_FULL) || pop);
   // The output register only refills from storage, never straight from the input.
   assign load   = (mem_cnt != '0) && (!out_vld || pop) && !CLEAR;
   assign frame_done = pop && out_ent.eof && (state == ST_RUN);

   always_comb begin
      level_nxt = level;
      if (CLEAR)
         level_nxt = '0;
      else if (wr_acc && !pop)
         level_nxt = level + LVL_ONE;
      else if (!wr_acc && pop)
         level_nxt = level - LVL_ONE;
   end

   always_ff @(posedge ACLK) begin
      if (wr_acc)
         mem[wr_ptr] <= wr_ent;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         level   <= '0;
         out_vld <= 1'b0;
         out_ent <= '0;
      end else begin
         level <= level_nxt;
         if (CLEAR) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            out_vld <= 1'b0;
         end else begin
            if (wr_acc)
               wr_ptr <= wr_ptr + PTR_ONE;
            if (load)
               rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_acc && !load)
               mem_cnt <= mem_cnt + LVL_ONE;
            else if (!wr_acc && load)
               mem_cnt <= mem_cnt - LVL_ONE;
            if (load) begin
               out_vld <= 1'b1;
               out_ent <= mem[rd_ptr];
            end else if (pop) begin
               out_vld <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state      <= ST_IDLE;
         frame_busy <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
         in_hold    <= 1'b0;
      end else begin
         in_hold <= (LVL_FULL - level_nxt) <= LVL_MARGIN;
         if (CLEAR) begin
            state      <= ST_IDLE;
            frame_busy <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
         end else begin
            if (PIX_VALID && !wr_acc)
               overflow <= 1'b1;
            case (state)
               ST_IDLE: begin
                  if (wr_acc && wr_sof) begin
                     state      <= ST_RUN;
                     frame_busy <= 1'b1;
                  end
               end
               ST_RUN: begin
                  // A new SOF overlapping the closing EOF pop keeps the next frame running.
                  if (wr_acc && wr_sof)
                     frame_err <= 1'b1;
                  else if (frame_done) begin
                     state      <= ST_IDLE;
                     frame_busy <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign M_AXIS_TDATA  = {8'd0, out_ent.rgb};
   assign M_AXIS_TVALID = out_vld;
   assign M_AXIS_TLAST  = out_ent.eol;
   assign M_AXIS_TUSER  = out_ent.sof;
   assign IN_HOLD       = in_hold;
   assign LEVEL         = level;
   assign OVERFLOW      = overflow;
   assign FRAME_ERR     = frame_err;
   assign FRAME_BUSY    = frame_busy;
   assign FRAME_DONE    = frame_done;

endmodule
